// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use hazards, EX redirects,
// multi-cycle data-memory waits with timeout, and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REGISTER_ADDR_WIDTH = 5,
  parameter int unsigned MAX_WAIT            = 16,
  parameter int unsigned WAIT_CNT_WIDTH      = 8,
  parameter int unsigned PERF_WIDTH          = 32
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst_n,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID_i,
  input  logic                           rs1_used_ID_i,
  input  logic                           rs2_used_ID_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_i,
  input  logic                           mem_read_EX_i,
  input  logic                           pc_redirect_EX_i,
  input  logic                           dmem_access_MEM_i,
  input  logic                           dmem_ready_i,
  output logic                           dmem_req_o,
  output logic                           stall_PC_o,
  output logic                           stall_IF_ID_o,
  output logic                           stall_ID_EX_o,
  output logic                           stall_EX_MEM_o,
  output logic                           flush_IF_ID_o,
  output logic                           flush_ID_EX_o,
  output logic                           bubble_MEM_WB_o,
  output logic                           mem_timeout_o,
  output logic [1:0]                     state_o,
  output logic [PERF_WIDTH-1:0]          stall_cycles_o,
  output logic [PERF_WIDTH-1:0]          flush_count_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_e;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(MAX_WAIT - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE  = WAIT_CNT_WIDTH'(1);
  localparam logic [PERF_WIDTH-1:0]     PERF_MAX  = '1;
  localparam logic [PERF_WIDTH-1:0]     PERF_ONE  = PERF_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [PERF_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
  logic [PERF_WIDTH-1:0]     flush_cnt_q, flush_cnt_d;

  logic in_error;
  logic mem_stall;
  logic rs1_match;
  logic rs2_match;
  logic lu_hazard;
  logic redirect_taken;

  assign in_error  = (state_q == ST_ERROR);
  assign mem_stall = dmem_access_MEM_i & ~dmem_ready_i & ~in_error;
  assign rs1_match = rs1_used_ID_i & (rs1_ID_i == rd_EX_i);
  assign rs2_match = rs2_used_ID_i & (rs2_ID_i == rd_EX_i);
  assign lu_hazard = mem_read_EX_i & (rd_EX_i != '0) & (rs1_match | rs2_match);

  // Next state and wait counter
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_access_MEM_i || dmem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Prioritised pipeline controls; everything is held low while reset is asserted
  always_comb begin
    dmem_req_o      = 1'b0;
    stall_PC_o      = 1'b0;
    stall_IF_ID_o   = 1'b0;
    stall_ID_EX_o   = 1'b0;
    stall_EX_MEM_o  = 1'b0;
    flush_IF_ID_o   = 1'b0;
    flush_ID_EX_o   = 1'b0;
    bubble_MEM_WB_o = 1'b0;
    mem_timeout_o   = 1'b0;
    redirect_taken  = 1'b0;
    if (cpu_rst_n) begin
      dmem_req_o = dmem_access_MEM_i & ~in_error;
      if (in_error) begin
        stall_PC_o      = 1'b1;
        stall_IF_ID_o   = 1'b1;
        stall_ID_EX_o   = 1'b1;
        stall_EX_MEM_o  = 1'b1;
        bubble_MEM_WB_o = 1'b1;
        mem_timeout_o   = 1'b1;
      end else if (mem_stall) begin
        stall_PC_o      = 1'b1;
        stall_IF_ID_o   = 1'b1;
        stall_ID_EX_o   = 1'b1;
        stall_EX_MEM_o  = 1'b1;
        bubble_MEM_WB_o = 1'b1;
      end else if (pc_redirect_EX_i) begin
        // The ID instruction is squashed, so any load-use stall is moot
        flush_IF_ID_o  = 1'b1;
        flush_ID_EX_o  = 1'b1;
        redirect_taken = 1'b1;
      end else if (lu_hazard) begin
        stall_PC_o    = 1'b1;
        stall_IF_ID_o = 1'b1;
        flush_ID_EX_o = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_PC_o && !in_error && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end
    if (redirect_taken && (flush_cnt_q != PERF_MAX)) begin
      flush_cnt_d = flush_cnt_q + PERF_ONE;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN-state priority logic,
// hand sequences for memory waits, timeout and asynchronous reset.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned MW  = 4;
  localparam int unsigned WCW = 8;
  localparam int unsigned PW  = 32;
  localparam int NVEC = 12;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1, rs2, rd;
  logic          u1, u2, mrd, redir, acc, rdy;
  logic          dmem_req_o, stall_PC_o, stall_IF_ID_o, stall_ID_EX_o, stall_EX_MEM_o;
  logic          flush_IF_ID_o, flush_ID_EX_o, bubble_MEM_WB_o, mem_timeout_o;
  logic [1:0]    state_o;
  logic [PW-1:0] stall_cycles_o, flush_count_o;

  pipeline_hazard_ctrl #(
    .REGISTER_ADDR_WIDTH(AW),
    .MAX_WAIT(MW),
    .WAIT_CNT_WIDTH(WCW),
    .PERF_WIDTH(PW)
  ) dut (
    .cpu_clk(clk),
    .cpu_rst_n(rst_n),
    .rs1_ID_i(rs1),
    .rs2_ID_i(rs2),
    .rs1_used_ID_i(u1),
    .rs2_used_ID_i(u2),
    .rd_EX_i(rd),
    .mem_read_EX_i(mrd),
    .pc_redirect_EX_i(redir),
    .dmem_access_MEM_i(acc),
    .dmem_ready_i(rdy),
    .dmem_req_o(dmem_req_o),
    .stall_PC_o(stall_PC_o),
    .stall_IF_ID_o(stall_IF_ID_o),
    .stall_ID_EX_o(stall_ID_EX_o),
    .stall_EX_MEM_o(stall_EX_MEM_o),
    .flush_IF_ID_o(flush_IF_ID_o),
    .flush_ID_EX_o(flush_ID_EX_o),
    .bubble_MEM_WB_o(bubble_MEM_WB_o),
    .mem_timeout_o(mem_timeout_o),
    .state_o(state_o),
    .stall_cycles_o(stall_cycles_o),
    .flush_count_o(flush_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, bubble}
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          mrd;
    logic          redir;
    logic          acc;
    logic          rdy;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_checks;
  int   n_pass;
  int   sc_exp;
  int   fc_exp;

  function automatic logic [7:0] ctl();
    return {dmem_req_o, stall_PC_o, stall_IF_ID_o, stall_ID_EX_o, stall_EX_MEM_o,
            flush_IF_ID_o, flush_ID_EX_o, bubble_MEM_WB_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic e1,
                       input logic e2, input logic [AW-1:0] d, input logic m, input logic r,
                       input logic a, input logic y);
    rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mrd = m; redir = r; acc = a; rdy = y;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " stall_cycles"}, stall_cycles_o, 32'(sc_exp));
    chk({tag, " flush_count"}, flush_count_o, 32'(fc_exp));
  endtask

  // Multi-cycle access: three not-ready cycles then ready; optional redirect / load-use alongside
  task automatic run_wait(input logic r, input logic lu);
    for (int c = 0; c < 3; c++) begin
      drive(5'd6, 5'd0, lu, 1'b0, 5'd6, lu, r, 1'b1, 1'b0);
      @(negedge clk);
      chk("wait ctl", 32'(ctl()), 32'h0F9);
      chk("wait state", 32'(state_o), (c == 0) ? 32'd0 : 32'd1);
      sc_exp++;
      step();
    end
    drive(5'd6, 5'd0, lu, 1'b0, 5'd6, lu, r, 1'b1, 1'b1);
    @(negedge clk);
    chk("ready ctl", 32'(ctl()), r ? 32'h086 : (lu ? 32'h0E2 : 32'h080));
    chk("ready state", 32'(state_o), 32'd1);
    if (r) fc_exp++;
    else if (lu) sc_exp++;
    step();
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post-wait ctl", 32'(ctl()), 32'h000);
    chk("post-wait state", 32'(state_o), 32'd0);
    chk_counters("post-wait");
    step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; sc_exp = 0; fc_exp = 0;
    //            rs1   rs2   u1    u2    rd    mrd   redir acc   rdy   exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h62};
    vecs[2]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h62};
    vecs[6]  = '{5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{5'd5, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
    vecs[10] = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE2};
    vecs[11] = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 8'h86};

    // Reset with hazards and a stalled access on the inputs: all controls must stay low
    rst_n = 1'b0;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    chk("reset ctl", 32'(ctl()), 32'h000);
    chk("reset state", 32'(state_o), 32'd0);
    chk("reset timeout", 32'(mem_timeout_o), 32'd0);
    repeat (2) @(posedge clk);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_counters("reset");
    step();

    // Single-cycle RUN-state priority vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].mrd, vecs[i].redir, vecs[i].acc, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'd0);
      chk_counters($sformatf("vec%0d", i));
      sc_exp += int'(vecs[i].exp[6]);
      fc_exp += int'(vecs[i].exp[2]);
      step();
    end
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("table stall_cycles total", stall_cycles_o, 32'd3);
    chk("table flush_count total", flush_count_o, 32'd2);
    step();

    run_wait(1'b0, 1'b1);
    run_wait(1'b1, 1'b0);

    // Timeout: MAX_WAIT not-ready cycles enter ERROR, which holds regardless of ready
    for (int c = 0; c < int'(MW); c++) begin
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("to-wait ctl", 32'(ctl()), 32'h0F9);
      chk("to-wait state", 32'(state_o), (c == 0) ? 32'd0 : 32'd1);
      chk("to-wait timeout", 32'(mem_timeout_o), 32'd0);
      sc_exp++;
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, (c == 2), 1'b1, (c > 0));
      @(negedge clk);
      chk("error ctl", 32'(ctl()), 32'h079);
      chk("error state", 32'(state_o), 32'd2);
      chk("error timeout", 32'(mem_timeout_o), 32'd1);
      chk_counters("error");
      step();
    end

    // Asynchronous reset in the middle of a memory wait
    rst_n = 1'b0;
    #1;
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("error cleared state", 32'(state_o), 32'd0);
    step();
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("pre-reset state", 32'(state_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async ctl", 32'(ctl()), 32'h000);
    chk("async state", 32'(state_o), 32'd0);
    chk("async stall_cycles", stall_cycles_o, 32'd0);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-release ctl", 32'(ctl()), 32'h000);
    chk("post-release state", 32'(state_o), 32'd0);
    chk("post-release stall_cycles", stall_cycles_o, 32'd0);
    chk("post-release flush_count", flush_count_o, 32'd0);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("post-release access ctl", 32'(ctl()), 32'h080);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
